// File: rtl/fetch_predict.sv
// Instruction-fetch stage: PC register, 2-bit-counter BHT plus BTB, and the IF/ID register.
// Define BRANCH_PREDICT_EN to build the predictor; otherwise fetch falls through to PC+4.
module fetch_predict #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        id_jump,
  input  logic [31:0] id_jump_pc,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_pred_taken,
  output logic        ifid_valid
);

  localparam int TAG_W   = 30 - BHT_IDX_W;
  localparam int ENTRIES = 1 << BHT_IDX_W;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred_taken;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_pc;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef BRANCH_PREDICT_EN
  logic [BHT_IDX_W-1:0] idx, uidx;
  logic [TAG_W-1:0]     tag, utag;

  logic [1:0]         cnt_q        [ENTRIES];
  logic [1:0]         cnt_d        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
  logic [TAG_W-1:0]   btb_tag_d    [ENTRIES];
  logic [31:0]        btb_target_q [ENTRIES];
  logic [31:0]        btb_target_d [ENTRIES];

  logic unused_upd_lsb;
  assign unused_upd_lsb = ^upd_pc[1:0];

  assign idx  = pc_q[BHT_IDX_W+1:2];
  assign tag  = pc_q[31:BHT_IDX_W+2];
  assign uidx = upd_pc[BHT_IDX_W+1:2];
  assign utag = upd_pc[31:BHT_IDX_W+2];

  // Lookup reads only _q state, so a same-cycle update at this index is seen next cycle.
  always_comb begin
    pred_taken = cnt_q[idx][1] & btb_valid_q[idx] & (btb_tag_q[idx] == tag);
    pred_pc    = pred_taken ? btb_target_q[idx] : pc_plus4;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d        = cnt_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_en) begin
      if (upd_taken) begin
        if (cnt_q[uidx] != 2'b11) cnt_d[uidx] = cnt_q[uidx] + 2'd1;
        btb_valid_d[uidx]  = 1'b1;
        btb_tag_d[uidx]    = utag;
        btb_target_d[uidx] = upd_target;
      end else if (cnt_q[uidx] != 2'b00) begin
        cnt_d[uidx] = cnt_q[uidx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
      btb_valid_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      btb_valid_q <= btb_valid_d;
    end
  end

  // NOTE: BTB tag/target arrays are deliberately unreset; btb_valid_q gates every use of them.
  always_ff @(posedge clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
  end
`else
  logic unused_upd;
  assign unused_upd = ^{upd_en, upd_pc, upd_taken, upd_target};
  assign pred_taken = 1'b0;
  assign pred_pc    = pc_plus4;
`endif

  // Redirect beats stall, stall beats jump, jump beats sequential/predicted fetch.
  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    if (ex_redirect) begin
      pc_d   = ex_redirect_pc;
      ifid_d = BUBBLE;
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else if (id_jump) begin
      pc_d   = id_jump_pc;
      ifid_d = BUBBLE;
    end else begin
      pc_d              = pred_pc;
      ifid_d.instr      = imem_data;
      ifid_d.pc         = pc_q;
      ifid_d.pc4        = pc_plus4;
      ifid_d.pred_taken = pred_taken;
      ifid_d.valid      = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= BUBBLE;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr       = pc_q;
  assign ifid_instr      = ifid_q.instr;
  assign ifid_pc         = ifid_q.pc;
  assign ifid_pc4        = ifid_q.pc4;
  assign ifid_pred_taken = ifid_q.pred_taken;
  assign ifid_valid      = ifid_q.valid;

endmodule

// File: tb/tb_fetch_predict.sv
// Scoreboard bench for fetch_predict: each scenario queues stimulus and expected IF state,
// then pops and compares one entry per clock. Expectations follow BRANCH_PREDICT_EN.
module tb_fetch_predict;

`ifdef BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, id_jump, ex_redirect, upd_en, upd_taken;
  logic [31:0] id_jump_pc, ex_redirect_pc, upd_pc, upd_target;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_pred_taken, ifid_valid;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
    logic        valid;
  } obs_t;

  typedef struct packed {
    logic        stall;
    logic        jump;
    logic [31:0] jpc;
    logic        redir;
    logic [31:0] rpc;
    logic        upd;
    logic        utaken;
    logic [31:0] upc;
    logic [31:0] utgt;
  } stim_t;

  stim_t sq[$];
  obs_t  exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h2400_0000 ^ a;
  endfunction

  assign imem_data = instr_of(imem_addr);

  fetch_predict dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .id_jump(id_jump), .id_jump_pc(id_jump_pc),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_pred_taken(ifid_pred_taken), .ifid_valid(ifid_valid)
  );

  function automatic obs_t mk(input logic [31:0] addr, input logic [31:0] ipc,
                              input logic pred, input logic valid);
    obs_t o;
    o.addr  = addr;
    o.instr = valid ? instr_of(ipc) : 32'h0;
    o.pc    = valid ? ipc : 32'h0;
    o.pc4   = valid ? ipc + 32'd4 : 32'h0;
    o.pred  = pred;
    o.valid = valid;
    return o;
  endfunction

  function automatic obs_t sample();
    return {imem_addr, ifid_instr, ifid_pc, ifid_pc4, ifid_pred_taken, ifid_valid};
  endfunction

  function automatic stim_t st(input logic s, input logic j, input logic [31:0] jpc,
                               input logic r, input logic [31:0] rpc);
    stim_t x = '0;
    x.stall = s; x.jump = j; x.jpc = jpc; x.redir = r; x.rpc = rpc;
    return x;
  endfunction

  function automatic stim_t stu(input stim_t base, input logic tk,
                                input logic [31:0] upc, input logic [31:0] utgt);
    stim_t x = base;
    x.upd = 1'b1; x.utaken = tk; x.upc = upc; x.utgt = utgt;
    return x;
  endfunction

  task automatic apply(input stim_t x);
    stall = x.stall; id_jump = x.jump; id_jump_pc = x.jpc;
    ex_redirect = x.redir; ex_redirect_pc = x.rpc;
    upd_en = x.upd; upd_taken = x.utaken; upd_pc = x.upc; upd_target = x.utgt;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    apply('0);
    rst = 1'b1;
    exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0));
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) cycle();
      o = sample(); e = exp_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b", i,
                 o.addr, o.instr, o.pc, o.pc4, o.pred, o.valid,
                 e.addr, e.instr, e.pc, e.pc4, e.pred, e.valid);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch_stall_jump();
    obs_t o, e;
    int i = 0;
    sq.push_back(st(0, 0, 0, 0, 0));          exp_q.push_back(mk(32'h4,  32'h0,  0, 1));
    sq.push_back(st(0, 0, 0, 0, 0));          exp_q.push_back(mk(32'h8,  32'h4,  0, 1));
    sq.push_back(st(1, 0, 0, 0, 0));          exp_q.push_back(mk(32'h8,  32'h4,  0, 1));
    sq.push_back(st(1, 0, 0, 0, 0));          exp_q.push_back(mk(32'h8,  32'h4,  0, 1));
    sq.push_back(st(0, 0, 0, 0, 0));          exp_q.push_back(mk(32'hC,  32'h8,  0, 1));
    sq.push_back(st(0, 1, 32'h40, 0, 0));     exp_q.push_back(mk(32'h40, 32'h0,  0, 0));
    sq.push_back(st(0, 0, 0, 0, 0));          exp_q.push_back(mk(32'h44, 32'h40, 0, 1));
    sq.push_back(st(1, 1, 32'h80, 0, 0));     exp_q.push_back(mk(32'h44, 32'h40, 0, 1));
    sq.push_back(st(0, 0, 0, 0, 0));          exp_q.push_back(mk(32'h48, 32'h44, 0, 1));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      cycle();
      o = sample(); e = exp_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL fetch[%0d]: got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b", i,
                 o.addr, o.instr, o.pc, o.pc4, o.pred, o.valid,
                 e.addr, e.instr, e.pc, e.pc4, e.pred, e.valid);
      end
      i++;
    end
  endtask

  task automatic test_training();
    obs_t o, e;
    int i = 0;
    logic [31:0] tk = PE ? 32'h80 : 32'h14;
    stim_t idle = st(0, 0, 0, 0, 0);
    stim_t r10  = st(0, 0, 0, 1, 32'h10);
    sq.push_back(stu(r10, 1, 32'h10, 32'h80));   exp_q.push_back(mk(32'h10, 0, 0, 0));
    sq.push_back(idle);                          exp_q.push_back(mk(tk, 32'h10, PE, 1));
    sq.push_back(stu(idle, 0, 32'h10, 0));       exp_q.push_back(mk(tk + 32'h4, tk, 0, 1));
    sq.push_back(stu(idle, 0, 32'h10, 0));       exp_q.push_back(mk(tk + 32'h8, tk + 32'h4, 0, 1));
    sq.push_back(r10);                           exp_q.push_back(mk(32'h10, 0, 0, 0));
    sq.push_back(idle);                          exp_q.push_back(mk(32'h14, 32'h10, 0, 1));
    sq.push_back(stu(r10, 1, 32'h10, 32'h80));   exp_q.push_back(mk(32'h10, 0, 0, 0));
    sq.push_back(stu(idle, 1, 32'h10, 32'h80));  exp_q.push_back(mk(32'h14, 32'h10, 0, 1));
    sq.push_back(stu(r10, 1, 32'h10, 32'h80));   exp_q.push_back(mk(32'h10, 0, 0, 0));
    sq.push_back(stu(idle, 1, 32'h10, 32'h80));  exp_q.push_back(mk(tk, 32'h10, PE, 1));
    sq.push_back(stu(r10, 0, 32'h10, 0));        exp_q.push_back(mk(32'h10, 0, 0, 0));
    sq.push_back(idle);                          exp_q.push_back(mk(tk, 32'h10, PE, 1));
    sq.push_back(st(0, 0, 0, 1, 32'h50));        exp_q.push_back(mk(32'h50, 0, 0, 0));
    sq.push_back(idle);                          exp_q.push_back(mk(32'h54, 32'h50, 0, 1));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      cycle();
      o = sample(); e = exp_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL train[%0d]: got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b", i,
                 o.addr, o.instr, o.pc, o.pc4, o.pred, o.valid,
                 e.addr, e.instr, e.pc, e.pc4, e.pred, e.valid);
      end
      i++;
    end
  endtask

  task automatic test_priority_wrap();
    obs_t o, e;
    int i = 0;
    sq.push_back(st(1, 1, 32'h40, 1, 32'h100));   exp_q.push_back(mk(32'h100, 0, 0, 0));
    sq.push_back(st(0, 1, 32'h40, 1, 32'h200));   exp_q.push_back(mk(32'h200, 0, 0, 0));
    sq.push_back(st(0, 0, 0, 0, 0));              exp_q.push_back(mk(32'h204, 32'h200, 0, 1));
    sq.push_back(st(0, 0, 0, 1, 32'hFFFF_FFFC));  exp_q.push_back(mk(32'hFFFF_FFFC, 0, 0, 0));
    sq.push_back(st(0, 0, 0, 0, 0));              exp_q.push_back(mk(32'h0, 32'hFFFF_FFFC, 0, 1));
    sq.push_back(st(0, 0, 0, 0, 0));              exp_q.push_back(mk(32'h4, 32'h0, 0, 1));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      cycle();
      o = sample(); e = exp_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL prio[%0d]: got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b", i,
                 o.addr, o.instr, o.pc, o.pc4, o.pred, o.valid,
                 e.addr, e.instr, e.pc, e.pc4, e.pred, e.valid);
      end
      i++;
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    apply('0);
    #2;
    rst = 1'b1;
    exp_q.push_back(mk(32'h0, 0, 0, 0));
    #1;
    o = sample(); e = exp_q.pop_front(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL async_rst: got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b",
               o.addr, o.instr, o.pc, o.pc4, o.pred, o.valid,
               e.addr, e.instr, e.pc, e.pc4, e.pred, e.valid);
    end
    cycle();
    rst = 1'b0;
    sq.push_back(st(0, 0, 0, 1, 32'h10));  exp_q.push_back(mk(32'h10, 0, 0, 0));
    sq.push_back(st(0, 0, 0, 0, 0));       exp_q.push_back(mk(32'h14, 32'h10, 0, 1));
    for (int i = 0; sq.size() > 0; i++) begin
      apply(sq.pop_front());
      cycle();
      o = sample(); e = exp_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL post_rst[%0d]: got %h/%h/%h/%h/%b/%b want %h/%h/%h/%h/%b/%b", i,
                 o.addr, o.instr, o.pc, o.pc4, o.pred, o.valid,
                 e.addr, e.instr, e.pc, e.pc4, e.pred, e.valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stall_jump();
    test_training();
    test_priority_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
